// File: rtl/aes_inv_round.sv
// aes_inv_round: iterative AES-128 inverse cipher round.
// InvShiftRows on capture, InvSubBytes in the SUB state, then AddRoundKey
// and (unless the final round is flagged) InvMixColumns in the MIX state.
// Optional build macro: AES_INV_ROUND_SBOX16_EN. When it is defined, 16 inv_s_box
// instances substitute the whole state in one SUB cycle. When it is undefined,
// 4 shared instances walk the columns over four cycles.

// inv_s_box: AES inverse S-box, y = inverse_GF(2^8)(InvAffine(x)).
module inv_s_box (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] pre;
  logic [7:0] sq;
  logic [7:0] acc;

  // Inverse affine map, then x^254 (the field inverse, 0 maps to 0)
  always_comb begin
    pre = {in_byte[6:0], in_byte[7]} ^ {in_byte[4:0], in_byte[7:5]} ^
          {in_byte[1:0], in_byte[7:2]} ^ 8'h05;
    sq  = pre;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    out_byte = acc;
  end

endmodule

module aes_inv_round (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

  state_t       state_reg;
  state_t       state_next;
  logic [127:0] st_reg;
  logic [127:0] key_reg;
  logic [127:0] out_reg;
  logic         last_reg;
  logic [127:0] st_shift;
  logic [127:0] st_sub;
  logic [127:0] mix_t;
  logic [127:0] mix_out;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns; rows are rotations of [0e 0b 0d 09]
  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    for (int r = 0; r < 4; r++) begin
      a[r]  = w[31-8*r -: 8];
      x2    = xt(a[r]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // InvShiftRows is pure wiring: out[r][c] = in[r][(c-r) mod 4]
  for (genvar gi = 0; gi < 16; gi++) begin : g_shift
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
    assign st_shift[127-8*gi -: 8] = state_in[127-8*SRC -: 8];
  end

`ifdef AES_INV_ROUND_SBOX16_EN
  // Whole-state substitution in a single cycle
  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    inv_s_box u_inv_s_box (
      .in_byte  (st_reg[127-8*gi -: 8]),
      .out_byte (st_sub[127-8*gi -: 8])
    );
  end
`else
  logic [1:0]  col_reg;
  logic [31:0] col_word;
  logic [31:0] sub_word;

  // Pick the column currently being substituted
  always_comb begin
    case (col_reg)
      2'd0:    col_word = st_reg[127:96];
      2'd1:    col_word = st_reg[95:64];
      2'd2:    col_word = st_reg[63:32];
      default: col_word = st_reg[31:0];
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    inv_s_box u_inv_s_box (
      .in_byte  (col_word[31-8*gi -: 8]),
      .out_byte (sub_word[31-8*gi -: 8])
    );
  end

  // Write the substituted column back into its slot, others unchanged
  always_comb begin
    st_sub = st_reg;
    case (col_reg)
      2'd0:    st_sub[127:96] = sub_word;
      2'd1:    st_sub[95:64]  = sub_word;
      2'd2:    st_sub[63:32]  = sub_word;
      default: st_sub[31:0]   = sub_word;
    endcase
  end
`endif

  assign mix_t = st_reg ^ key_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    assign mix_out[127-32*gi -: 32] = inv_mix_col(mix_t[127-32*gi -: 32]);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = SUB;
`ifdef AES_INV_ROUND_SBOX16_EN
      SUB:  state_next = MIX;
`else
      SUB:  if (col_reg == 2'd3) state_next = MIX;
`endif
      MIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: capture, per-column substitution, final result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_reg   <= '0;
      key_reg  <= '0;
      last_reg <= 1'b0;
      out_reg  <= '0;
`ifndef AES_INV_ROUND_SBOX16_EN
      col_reg  <= 2'd0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            st_reg   <= st_shift;
            key_reg  <= round_key;
            last_reg <= last_round;
`ifndef AES_INV_ROUND_SBOX16_EN
            col_reg  <= 2'd0;
`endif
          end
        end
        SUB: begin
          st_reg  <= st_sub;
`ifndef AES_INV_ROUND_SBOX16_EN
          col_reg <= col_reg + 2'd1;
`endif
        end
        MIX:     out_reg <= last_reg ? mix_t : mix_out;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign state_out = out_reg;

endmodule

// File: tb/tb_aes_inv_round.sv
// Testbench for aes_inv_round: directed vectors, random traffic against a
// byte-level reference model, backpressure and mid-operation reset.
// Honours AES_INV_ROUND_SBOX16_EN for the expected latency and period.
module tb_aes_inv_round;

`ifdef AES_INV_ROUND_SBOX16_EN
  localparam int LAT = 2;
  localparam int PER = 4;
`else
  localparam int LAT = 5;
  localparam int PER = 7;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int errors = 0;
  int checks = 0;
  int ntx = 0;
  int cyc_cnt = 0;
  int last_acc = 0;
  logic [127:0] exp_q [$];
  logic [127:0] mon_exp;

  logic [7:0] inv_t [256];
  logic [7:0] inv_sbox_t [256];

  aes_inv_round dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .state_in   (state_in),
    .round_key  (round_key),
    .last_round (last_round),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic check128(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // Forward S-box from its definition, then invert it as a lookup table
  task automatic build_tables();
    logic [7:0] s;
    logic [7:0] sb;
    for (int x = 0; x < 256; x++) begin
      inv_t[x] = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv_t[x] = 8'(y);
    end
    for (int x = 0; x < 256; x++) begin
      s  = inv_t[x];
      sb = s ^ rl(s, 1) ^ rl(s, 2) ^ rl(s, 3) ^ rl(s, 4) ^ 8'h63;
      inv_sbox_t[sb] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k, input logic l);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] o [16];
    logic [7:0] base [4];
    logic [127:0] res;
    base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = inv_sbox_t[b[4*((c - r + 4) % 4) + r]] ^ k[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (l) o[4*c+r] = t[4*c+r];
        else begin
          o[4*c+r] = 8'h00;
          for (int j = 0; j < 4; j++)
            o[4*c+r] = o[4*c+r] ^ gmul(base[(j - r + 4) % 4], t[4*c+j]);
        end
      end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_accept();
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_int("accept_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    state_in   = {$urandom, $urandom, $urandom, $urandom};
    round_key  = {$urandom, $urandom, $urandom, $urandom};
    last_round = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l,
                      input logic [127:0] want, input bit chk_lat, input bit chk_per);
    int cyc;
    in_valid   = 1'b1;
    state_in   = s;
    round_key  = k;
    last_round = l;
    wait_accept();
    exp_q.push_back(want);
    if (chk_per) check_int("period", cyc_cnt - last_acc, PER);
    last_acc = cyc_cnt;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      if (in_ready) begin
        errors++;
        checks++;
        $display("FAIL busy_in_ready: got 1 want 0");
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (chk_lat) check_int("latency", cyc, LAT);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_output: got %h want none", state_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check128("state_out", state_out, mon_exp);
        $display("txn %0d: state_out=%h expected=%h", ntx, state_out, mon_exp);
        ntx++;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] s;
    logic [127:0] k;
    logic         l;
    int           cyc;
    build_tables();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    state_in   = '0;
    round_key  = '0;
    last_round = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_int("reset_in_ready", int'(in_ready), 1);
    check_int("reset_out_valid", int'(out_valid), 0);
    check128("reset_state_out", state_out, 128'h0);
    @(posedge clk);
    #1;

    // Directed vectors
    send(128'h0, 128'h0, 1'b0, {4{32'h52525252}}, 1'b1, 1'b0);
    send(128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h0, 1'b1,
         128'h52f3a338_3009d79e_bf366afb_8140a5d5, 1'b1, 1'b1);
    send({4{32'h19e33265}}, 128'h0, 1'b0, {4{32'hdb135345}}, 1'b1, 1'b1);
    send(128'h0, {128{1'b1}}, 1'b1, {16{8'had}}, 1'b1, 1'b1);

    // Random traffic, back to back
    for (int i = 0; i < 40; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      l = 1'($urandom_range(0, 1));
      send(s, k, l, model(s, k, l), 1'b1, 1'b1);
    end

    // Backpressure: hold out_ready low for 10 cycles
    @(posedge clk);
    #1 out_ready = 1'b0;
    s = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    send(s, k, 1'b0, model(s, k, 1'b0), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_int("bp_out_valid", int'(out_valid), 1);
      check_int("bp_in_ready", int'(in_ready), 0);
      check128("bp_state_out", state_out, model(s, k, 1'b0));
      @(posedge clk);
      #1;
      in_valid  = 1'(i % 2);
      state_in  = {$urandom, $urandom, $urandom, $urandom};
      round_key = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_int("bp_release_in_ready", int'(in_ready), 1);
    check_int("bp_release_out_valid", int'(out_valid), 0);

    // Reset in the middle of SUB
    in_valid  = 1'b1;
    state_in  = {4{32'h19e33265}};
    round_key = {$urandom, $urandom, $urandom, $urandom};
    wait_accept();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_int("midrst_out_valid", int'(out_valid), 0);
    check128("midrst_state_out", state_out, 128'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_int("midrst_in_ready", int'(in_ready), 1);
    check_int("midrst_out_valid_rel", int'(out_valid), 0);
    check128("midrst_state_out_rel", state_out, 128'h0);
    @(posedge clk);
    #1;
    send(128'h0, 128'h0, 1'b0, {4{32'h52525252}}, 1'b1, 1'b0);

    // Drain the scoreboard
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    @(posedge clk);
    check_int("scoreboard_empty", exp_q.size(), 0);
    check_int("transactions_seen", ntx, 46);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
